// File: rtl/cpu_controller.sv
// Instruction-cycle sequencer for the 8-bit RISC CPU: an eight-phase counter
// plus a halted flag, with all strobes decoded from phase, opcode and zero.
module cpu_controller #(
  parameter logic [2:0] OP_HLT = 3'd0,
  parameter logic [2:0] OP_SKZ = 3'd1,
  parameter logic [2:0] OP_ADD = 3'd2,
  parameter logic [2:0] OP_AND = 3'd3,
  parameter logic [2:0] OP_XOR = 3'd4,
  parameter logic [2:0] OP_LDA = 3'd5,
  parameter logic [2:0] OP_STO = 3'd6,
  parameter logic [2:0] OP_JMP = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       halt,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr,
  output logic [2:0] phase
);

  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  logic [2:0] phase_reg;
  logic       halted_reg;
  logic       aluop;
  logic       is_hlt;
  logic       is_skz;
  logic       is_sto;
  logic       is_jmp;

  // A HLT seen in OP_ADDR freezes the counter there; only reset releases it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_reg  <= PH_INST_ADDR;
      halted_reg <= 1'b0;
    end else if (!halted_reg) begin
      if (phase_reg == PH_OP_ADDR && is_hlt) begin
        halted_reg <= 1'b1;
      end else begin
        phase_reg <= phase_reg + 3'd1;
      end
    end
  end

  assign aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign phase  = phase_reg;

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    if (halted_reg) begin
      halt = 1'b1;
    end else begin
      case (phase_reg)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
        end
        PH_OP_FETCH: begin
          rd = aluop;
        end
        PH_ALU_OP: begin
          rd     = aluop;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        PH_STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Randomised self-checking bench for cpu_controller against a rule-based
// model of the instruction cycle (phase counter, halt latch, strobe rules).
module tb_cpu_controller;

  logic       clk;
  logic       reset;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;
  int m_phase = 0;
  bit m_halted = 1'b0;

  cpu_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .halt(halt),
    .ld_pc(ld_pc), .data_e(data_e), .ld_ac(ld_ac), .wr(wr), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr phase[2:0]
  function automatic logic [11:0] observed();
    return {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, phase};
  endfunction

  // Each strobe written as its own rule over phase ranges and opcode classes.
  function automatic logic [11:0] model_outs(int ph, bit hl, logic [2:0] op, logic z);
    bit alu, e_sel, e_rd, e_ldir, e_inc, e_halt, e_ldpc, e_de, e_ldac, e_wr;
    alu    = (op >= 3'd2) && (op <= 3'd5);
    e_sel  = (ph <= 3);
    e_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    e_ldir = (ph == 2) || (ph == 3);
    e_inc  = (ph == 4) || (ph == 6 && op == 3'd1 && z);
    e_halt = (ph == 4) && (op == 3'd0);
    e_ldpc = (ph >= 6) && (op == 3'd7);
    e_de   = (ph >= 6) && (op == 3'd6);
    e_ldac = (ph == 7) && alu;
    e_wr   = (ph == 7) && (op == 3'd6);
    if (hl) return {4'b0000, 1'b1, 4'b0000, 3'(ph)};
    return {e_sel, e_rd, e_ldir, e_inc, e_halt, e_ldpc, e_de, e_ldac, e_wr, 3'(ph)};
  endfunction

  // Advance one clock and evolve the model with the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m_phase  = 0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
      else m_phase = (m_phase + 1) % 8;
    end
    #1;
  endtask

  task automatic align_to_phase0();
    for (int k = 0; k < 8 && m_phase != 0; k++) begin
      opcode = 3'd2;
      tick();
    end
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    reset = 1'b0; opcode = 3'd5; zero = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    obs = observed();
    checks++;
    if (obs !== 12'h800) begin
      errors++;
      $display("FAIL reset_state got %b want %b", obs, 12'h800);
    end else $display("reset_state ok %b", obs);
    for (int i = 1; i <= 9; i++) begin
      tick();
      #1;
      obs = observed();
      checks++;
      if (obs[2:0] !== 3'(i % 8) || obs !== model_outs(m_phase, m_halted, opcode, zero)) begin
        errors++;
        $display("FAIL reset_step%0d got %b want phase %0d vec %b", i, obs, i % 8,
                 model_outs(m_phase, m_halted, opcode, zero));
      end else $display("reset_step%0d ok phase %0d", i, obs[2:0]);
    end
  endtask

  // Runs one full instruction with a fixed opcode/zero and checks every phase.
  task automatic run_instr(input string name, input logic [2:0] op, input logic z);
    logic [11:0] obs, exp;
    align_to_phase0();
    opcode = op; zero = z;
    for (int i = 0; i < 8; i++) begin
      #1;
      obs = observed();
      exp = model_outs(m_phase, m_halted, opcode, zero);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s ph%0d got %b want %b", name, i, obs, exp);
      end else $display("%s ph%0d ok %b", name, i, obs);
      tick();
    end
  endtask

  task automatic test_lda();
    run_instr("lda", 3'd5, 1'b0);
    run_instr("add", 3'd2, 1'b1);
  endtask

  task automatic test_skz();
    run_instr("skz_z1", 3'd1, 1'b1);
    run_instr("skz_z0", 3'd1, 1'b0);
  endtask

  task automatic test_sto_jmp();
    run_instr("sto", 3'd6, 1'b0);
    run_instr("jmp", 3'd7, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_xor", 3'd4, 1'b0);
    run_instr("b2b_and", 3'd3, 1'b1);
    run_instr("b2b_sto", 3'd6, 1'b1);
  endtask

  task automatic test_hlt();
    logic [11:0] obs, exp;
    align_to_phase0();
    opcode = 3'd0; zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      obs = observed();
      exp = model_outs(m_phase, m_halted, opcode, zero);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL hlt_ph%0d got %b want %b", i, obs, exp);
      end else $display("hlt_ph%0d ok %b", i, obs);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      opcode = 3'($urandom_range(0, 7));
      zero = 1'($urandom_range(0, 1));
      #1;
      obs = observed();
      checks++;
      if (obs !== 12'h084) begin
        errors++;
        $display("FAIL hlt_frozen%0d got %b want %b", i, obs, 12'h084);
      end else $display("hlt_frozen%0d ok %b", i, obs);
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    obs = observed();
    checks++;
    if (obs !== 12'h800) begin
      errors++;
      $display("FAIL hlt_exit got %b want %b", obs, 12'h800);
    end else $display("hlt_exit ok %b", obs);
  endtask

  task automatic test_reset_mid_op();
    logic [11:0] obs, exp;
    bit wr_seen;
    wr_seen = 1'b0;
    align_to_phase0();
    opcode = 3'd6; zero = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) reset = 1'b0;
      #1;
      obs = observed();
      exp = model_outs(m_phase, m_halted, opcode, zero);
      if (wr) wr_seen = 1'b1;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL midrst_ph%0d got %b want %b", i, obs, exp);
      end else $display("midrst_ph%0d ok %b", i, obs);
      tick();
    end
    reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      obs = observed();
      if (wr && i < 7) wr_seen = 1'b1;
      checks++;
      if (obs[2:0] !== 3'(i % 8) || obs !== model_outs(m_phase, m_halted, opcode, zero)) begin
        errors++;
        $display("FAIL midrst_restart%0d got %b want phase %0d", i, obs, i % 8);
      end else $display("midrst_restart%0d ok phase %0d", i, obs[2:0]);
      tick();
    end
    checks++;
    if (wr_seen) begin
      errors++;
      $display("FAIL midrst_wr got pulse want none");
    end else $display("midrst_wr ok no pulse");
  endtask

  task automatic test_random();
    logic [11:0] obs, exp;
    int halted_cycles;
    halted_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_phase == 0 && !m_halted) opcode = 3'($urandom_range(0, 7));
      zero = 1'($urandom_range(0, 1));
      halted_cycles = m_halted ? halted_cycles + 1 : 0;
      reset = ($urandom_range(0, 49) == 0 || halted_cycles > 6) ? 1'b0 : 1'b1;
      #1;
      obs = observed();
      exp = model_outs(m_phase, m_halted, opcode, zero);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rand%0d op %0d z %0d got %b want %b", i, opcode, zero, obs, exp);
      end else $display("rand%0d op %0d z %0d rst %0d ok %b", i, opcode, zero, reset, obs);
      tick();
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    opcode = 3'd0;
    zero = 1'b0;
    test_reset();
    test_lda();
    test_skz();
    test_sto_jmp();
    test_back_to_back();
    test_hlt();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
